divider: RTL and testbench

- Sequential unsigned radix-2 restoring divider; the inverse-operation companion to the team's Booth multiplier datapath.
- Uses the same op_start / op_clear / op_done handshake as the multiplier, so one controller drives both blocks.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.

---
 rtl/divider.sv | 124 ++++++++++++
 tb/tb_divider.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock.
// Shares the op_start / op_clear / op_done handshake with the Booth multiplier.
module divider #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             op_start,
    input  logic             op_clear,
    output logic             op_done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       fsm_state
);

    // Handshake: op_start is a request sampled only in IDLE; op_done is a level
    // that stays high in DONE until op_clear, which wins over everything but reset.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   div_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [CNT_W-1:0]   cnt;
    logic               dbz_r;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   diff;
    logic               fits;
    logic               last_iter;

    // The partial remainder gains the quotient msb and can reach WIDTH+1 bits,
    // so the trial subtraction carries two guard bits above the operand width.
    assign rem_shift = {rem_r, quo_r[WIDTH-1]};
    assign diff      = {1'b0, rem_shift} - {2'b00, div_r};
    assign fits      = (diff[WIDTH+1:WIDTH] == 2'b00);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (op_start) begin
                    state_nxt = (divisor != '0) ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (op_clear) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_r <= '0;
            rem_r <= '0;
            quo_r <= '0;
            cnt   <= '0;
            dbz_r <= 1'b0;
        end else if (op_clear) begin
            div_r <= '0;
            rem_r <= '0;
            quo_r <= '0;
            cnt   <= '0;
            dbz_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_start) begin
                        cnt <= '0;
                        if (divisor != '0) begin
                            div_r <= divisor;
                            quo_r <= dividend;
                            rem_r <= '0;
                            dbz_r <= 1'b0;
                        end else begin
                            div_r <= '0;
                            quo_r <= '1;
                            rem_r <= dividend;
                            dbz_r <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    rem_r <= fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], fits};
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign op_done     = (state == DONE);
    assign quotient    = quo_r;
    assign remainder   = rem_r;
    assign div_by_zero = dbz_r;
    assign fsm_state   = state;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the restoring divider: directed corner cases,
// handshake/abort scenarios and a randomized run against a reference model.
module tb_divider;

    localparam int W = 64;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         op_start;
    logic         op_clear;
    logic         op_done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   fsm_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_r[$];

    int n_tests = 0;
    int n_fail  = 0;

    divider #(.WIDTH(W), .CNT_W(7)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dividend    (dividend),
        .divisor     (divisor),
        .op_start    (op_start),
        .op_clear    (op_clear),
        .op_done     (op_done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: every step ends 1ns after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        if (b == '0) begin
            exp_q.push_back('1);
            exp_r.push_back(a);
        end else begin
            exp_q.push_back(a / b);
            exp_r.push_back(a % b);
        end
    endtask

    task automatic clear_op();
        op_clear = 1'b1;
        step();
        op_clear = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!op_done && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        op_start = 1'b0;
        op_clear = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) step();
        n_tests++;
        if (op_done !== 1'b0 || div_by_zero !== 1'b0 || quotient !== '0 ||
            remainder !== '0 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: done=%b dbz=%b q=%h r=%h st=%0d, required all zero",
                     op_done, div_by_zero, quotient, remainder, fsm_state);
        end
        #3 reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int cyc;
        logic [W-1:0] eq, er;
        start_op(64'd100, 64'd7);
        wait_done(cyc);
        eq = exp_q.pop_front();
        er = exp_r.pop_front();
        n_tests++;
        if (cyc !== 64) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, required 64", cyc);
        end
        n_tests++;
        if (quotient !== eq || remainder !== er || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=0",
                     quotient, remainder, div_by_zero, eq, er);
        end
        repeat (5) step();
        n_tests++;
        if (op_done !== 1'b1 || quotient !== eq || remainder !== er) begin
            n_fail++;
            $display("FAIL basic_hold: done=%b q=%0d r=%0d, required done=1 q=%0d r=%0d",
                     op_done, quotient, remainder, eq, er);
        end
        clear_op();
    endtask

    task automatic test_corners();
        int cyc;
        logic [W-1:0] eq, er;
        logic [W-1:0] a_tab[4];
        logic [W-1:0] b_tab[4];
        a_tab = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0001, 64'd0};
        b_tab = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd7};
        for (int i = 0; i < 4; i++) begin
            start_op(a_tab[i], b_tab[i]);
            wait_done(cyc);
            eq = exp_q.pop_front();
            er = exp_r.pop_front();
            n_tests++;
            if (op_done !== 1'b1 || quotient !== eq || remainder !== er) begin
                n_fail++;
                $display("FAIL corner_%0d: done=%b q=%h r=%h, required done=1 q=%h r=%h",
                         i, op_done, quotient, remainder, eq, er);
            end
            clear_op();
            n_tests++;
            if (op_done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
                n_fail++;
                $display("FAIL corner_clear_%0d: done=%b q=%h r=%h, required all zero",
                         i, op_done, quotient, remainder);
            end
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        logic [W-1:0] eq, er;
        start_op(64'd1234, 64'd0);
        wait_done(cyc);
        eq = exp_q.pop_front();
        er = exp_r.pop_front();
        n_tests++;
        if (cyc !== 0) begin
            n_fail++;
            $display("FAIL dbz_latency: got %0d extra cycles, required 0", cyc);
        end
        n_tests++;
        if (div_by_zero !== 1'b1 || quotient !== eq || remainder !== er) begin
            n_fail++;
            $display("FAIL dbz_result: dbz=%b q=%h r=%0d, required dbz=1 q=%h r=%0d",
                     div_by_zero, quotient, remainder, eq, er);
        end
        clear_op();
        n_tests++;
        if (div_by_zero !== 1'b0 || op_done !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_clear: dbz=%b done=%b, required 0 0", div_by_zero, op_done);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        logic [W-1:0] eq, er;
        start_op(64'd100, 64'd7);
        repeat (20) step();
        dividend = 64'd999;
        divisor  = 64'd0;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        dividend = 64'd55;
        divisor  = 64'd3;
        wait_done(cyc);
        eq = exp_q.pop_front();
        er = exp_r.pop_front();
        n_tests++;
        if (cyc + 21 !== 64) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d cycles, required 64", cyc + 21);
        end
        n_tests++;
        if (quotient !== eq || remainder !== er || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=0",
                     quotient, remainder, div_by_zero, eq, er);
        end
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        step();
        n_tests++;
        if (op_done !== 1'b1 || quotient !== eq || remainder !== er) begin
            n_fail++;
            $display("FAIL done_start_ignored: done=%b q=%0d r=%0d, required 1 %0d %0d",
                     op_done, quotient, remainder, eq, er);
        end
        clear_op();
    endtask

    task automatic test_clear_mid();
        int cyc;
        int seen_done;
        logic [W-1:0] eq, er;
        start_op(64'd100, 64'd7);
        void'(exp_q.pop_front());
        void'(exp_r.pop_front());
        repeat (29) step();
        op_clear = 1'b1;
        op_start = 1'b1;
        step();
        op_clear = 1'b0;
        op_start = 1'b0;
        n_tests++;
        if (op_done !== 1'b0 || fsm_state !== 2'd0 || quotient !== '0 || remainder !== '0) begin
            n_fail++;
            $display("FAIL clear_mid: done=%b st=%0d q=%h r=%h, required idle and zero",
                     op_done, fsm_state, quotient, remainder);
        end
        seen_done = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (op_done) seen_done++;
        end
        n_tests++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL clear_mid_stays_idle: op_done high %0d cycles, required 0", seen_done);
        end
        start_op(64'd1000, 64'd3);
        wait_done(cyc);
        eq = exp_q.pop_front();
        er = exp_r.pop_front();
        n_tests++;
        if (cyc !== 64 || quotient !== eq || remainder !== er) begin
            n_fail++;
            $display("FAIL clear_mid_restart: cyc=%0d q=%0d r=%0d, required 64 %0d %0d",
                     cyc, quotient, remainder, eq, er);
        end
        clear_op();
    endtask

    task automatic test_async_reset();
        int cyc;
        logic [W-1:0] eq, er;
        start_op(64'h0123_4567_89AB_CDEF, 64'd17);
        void'(exp_q.pop_front());
        void'(exp_r.pop_front());
        repeat (39) step();
        #3 reset_n = 1'b0;
        #1;
        n_tests++;
        if (op_done !== 1'b0 || quotient !== '0 || remainder !== '0 ||
            div_by_zero !== 1'b0 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: done=%b q=%h r=%h dbz=%b st=%0d, required zero",
                     op_done, quotient, remainder, div_by_zero, fsm_state);
        end
        repeat (2) step();
        #3 reset_n = 1'b1;
        step();
        start_op(64'd1000, 64'd10);
        wait_done(cyc);
        eq = exp_q.pop_front();
        er = exp_r.pop_front();
        n_tests++;
        if (cyc !== 64 || quotient !== eq || remainder !== er) begin
            n_fail++;
            $display("FAIL after_reset: cyc=%0d q=%0d r=%0d, required 64 %0d %0d",
                     cyc, quotient, remainder, eq, er);
        end
        clear_op();
    endtask

    task automatic test_random();
        int cyc;
        int bad;
        logic [W-1:0] a, b, eq, er;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            a = {$urandom(), $urandom()} >> $urandom_range(0, 40);
            b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            if (b == '0) b = 64'd1;
            start_op(a, b);
            wait_done(cyc);
            eq = exp_q.pop_front();
            er = exp_r.pop_front();
            n_tests++;
            if (op_done !== 1'b1 || quotient !== eq || remainder !== er) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_%0d: %h/%h q=%h r=%h, required q=%h r=%h",
                             i, a, b, quotient, remainder, eq, er);
            end
            clear_op();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_start_ignored();
        test_clear_mid();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
